uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_byte_tx between NUM_REQ byte sources. Round-robin grant at packet
//  boundaries, one byte per tx handshake, programmable inter-byte gap. Sits between
//  client logic (cmd replies, status dump, debug) and the uart_byte_tx instance.
// PARAMETERS
//  NUM_REQ     4      number of requesters (2..8)
//  GAP_CYCLES  0      idle clk cycles inserted after each tx_done (0 = back-to-back)
//  TIMEOUT     1_000_000  clk cycles to wait for tx_done (only with UART_TX_TIMEOUT_EN)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous reset, active-high
//  req_valid    in   NUM_REQ    requester i has a byte pending
//  req_data     in   8*NUM_REQ  byte of requester i at [8*i +: 8]
//  req_last     in   NUM_REQ    byte is last of packet; releases lock
//  req_ready    out  NUM_REQ    1-cycle pulse: byte of requester i accepted
//  cfg_baud_set in   3          baud code, sampled at packet start
//  tx_data      out  8          to uart_byte_tx.data
//  tx_send_en   out  1          to uart_byte_tx.send_en, 1-cycle pulse
//  tx_baud_set  out  3          to uart_byte_tx.baud_set, stable through packet
//  tx_done      in   1          from uart_byte_tx.tx_done (1-cycle pulse)
//  tx_busy      in   1          from uart_byte_tx.uart_state
//  busy         out  1          arbiter not IDLE or packet lock held
//  gnt_id       out  clog2(NUM_REQ) current/last granted requester
//  err_timeout  out  1          sticky timeout flag (0 when macro absent)
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = 0 (req 0 highest priority first); lock cleared;
//   tx_baud_set = 3'd0. Reset mid-byte abandons it; uart_byte_tx is reset separately.
//  FSM: IDLE -> LOAD -> SEND -> WAIT -> GAP -> (LOAD | IDLE).
//  IDLE: no lock: search req_valid from rr_ptr upward, wrapping; winner -> gnt_id,
//   tx_baud_set <= cfg_baud_set, lock set; go LOAD. Lock held: only gnt_id eligible.
//  LOAD: req_ready[gnt_id]=1 for this cycle only (valid still high guaranteed by
//   eligibility); tx_data <= byte; last_q <= req_last[gnt_id]. -> SEND.
//  SEND: wait until tx_busy=0, then tx_send_en=1 exactly one cycle. -> WAIT.
//  WAIT: stay until tx_done=1. -> GAP (or IDLE-path directly if GAP_CYCLES=0).
//  GAP: count GAP_CYCLES; then if last_q: clear lock, rr_ptr <= gnt_id+1 (mod NUM_REQ),
//   -> IDLE; else if req_valid[gnt_id] -> LOAD; else -> IDLE with lock held.
//  Latency: valid in IDLE -> req_ready 1 cycle later -> tx_send_en 1 cycle after that
//   (if tx_busy=0). Byte-to-byte spacing = frame time + GAP_CYCLES + 3 cycles.
//  Simultaneous valids: winner is first at/after rr_ptr; others wait, never dropped.
//  req_data/req_last sampled only in LOAD; changes elsewhere ignored.
//  Requester dropping valid mid-packet: lock held indefinitely (no preemption).
//  cfg_baud_set changes mid-packet: ignored until next packet start.
//  tx_done outside WAIT: ignored.
// CONFIGURATION
//  UART_TX_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT without tx_done ->
//   err_timeout <= 1 (sticky until rst), lock cleared, rr_ptr advanced, -> IDLE.
//  Undefined: no counter, WAIT waits forever, err_timeout tied 0.
// STRUCTURE
//  Package uart_pkg: FSM state encoding localparams, baud code constants
//   (BAUD_9600..BAUD_115200 matching uart_byte_tx baud_set), byte width 8.
//  Sub-module rr_arbiter (NUM_REQ): combinational req vector + rr_ptr -> one-hot/index
//   grant and any_req. FSM, gap counter, timeout counter in top.
// TESTING (bench drives uart_byte_tx model or real instance, clk 20 ns)
//  Single: req0 sends 8'hAA, last=1, baud 3'd4 -> one req_ready[0], one send_en,
//   tx_data=8'hAA, tx_baud_set=4, busy drops after tx_done.
//  Contention: req0..3 each 1-byte packet (8'h10..13) valid together -> serial order
//   10,11,12,13; repeat -> order continues from 0 again, no starvation.
//  Packet lock: req1 3-byte packet 8'h55,56,57 (last on 57) while req2 valid ->
//   55,56,57 sent contiguously before req2's byte.
//  Gap: GAP_CYCLES=100 -> exactly 100 + 3 cycles from tx_done to next send_en.
//  Baud change mid-packet: cfg_baud_set 4->1 after first byte -> tx_baud_set stays 4
//   for packet, 1 for next.
//  Timeout (UART_TX_TIMEOUT_EN, TIMEOUT=50, tx_done held 0) -> err_timeout=1 at cycle
//   50 of WAIT, FSM back to IDLE, next requester served.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Baud codes match the uart_byte_tx baud_set encoding.
package uart_pkg;

   localparam int unsigned ByteW = 8;

   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSend,
      StWait,
      StGap
   } state_e;

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
   output logic                       any_req_o
);
   import uart_pkg::*;

   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [IdW-1:0] idx;

   always_comb begin
      gnt_idx_o = '0;
      any_req_o = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = IdW'((32'(ptr_i) + i) % NUM_REQ);
         if (!any_req_o && req_i[idx]) begin
            any_req_o = 1'b1;
            gnt_idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_byte_tx between NUM_REQ byte sources, round-robin at packet boundaries.
// Define UART_TX_TIMEOUT_EN to add the tx_done watchdog and sticky err_timeout.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 0
`ifdef UART_TX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT    = 1_000_000
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [2:0]                 cfg_baud_set,
   output logic [7:0]                 tx_data,
   output logic                       tx_send_en,
   output logic [2:0]                 tx_baud_set,
   input  logic                       tx_done,
   input  logic                       tx_busy,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       err_timeout
);
   import uart_pkg::*;

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GapW-1:0]    GapMax = GapW'(GAP_CYCLES);
   localparam logic [NUM_REQ-1:0] ReqOne = NUM_REQ'(1);

   state_e           state_q, state_d;
   logic             lock_q, lock_d;
   logic             last_q, last_d;
   logic [IdW-1:0]   gnt_q, gnt_d;
   logic [IdW-1:0]   rr_q, rr_d;
   logic [ByteW-1:0] data_q, data_d;
   logic [2:0]       baud_q, baud_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [IdW-1:0]   arb_idx;
   logic             arb_any;
   logic             timeout_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req_i     (req_valid),
      .ptr_i     (rr_q),
      .gnt_idx_o (arb_idx),
      .any_req_o (arb_any)
   );

`ifdef UART_TX_TIMEOUT_EN
   localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

   logic [ToW-1:0] to_q, to_d;
   logic           err_q, err_d;

   always_comb begin
      to_d        = (state_q == StWait) ? to_q + 1'b1 : '0;
      timeout_hit = (state_q == StWait) && !tx_done && (to_q == ToLast);
      err_d       = err_q | timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lock_d     = lock_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      rr_d       = rr_q;
      data_d     = data_q;
      baud_d     = baud_q;
      gap_d      = gap_q;
      req_ready  = '0;
      tx_send_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            // While locked only the owner may continue; no re-arbitration.
            if (lock_q) begin
               if (req_valid[gnt_q]) state_d = StLoad;
            end else if (arb_any) begin
               gnt_d   = arb_idx;
               baud_d  = cfg_baud_set;
               lock_d  = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            req_ready = ReqOne << gnt_q;
            data_d    = req_data[ByteW*32'(gnt_q) +: ByteW];
            last_d    = req_last[gnt_q];
            state_d   = StSend;
         end
         StSend: begin
            if (!tx_busy) begin
               tx_send_en = 1'b1;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (tx_done) begin
               gap_d   = '0;
               state_d = StGap;
            end else if (timeout_hit) begin
               lock_d  = 1'b0;
               rr_d    = IdW'(wrap_inc(32'(gnt_q), NUM_REQ));
               state_d = StIdle;
            end
         end
         StGap: begin
            if (gap_q != GapMax) begin
               gap_d = gap_q + 1'b1;
            end else if (last_q) begin
               lock_d  = 1'b0;
               rr_d    = IdW'(wrap_inc(32'(gnt_q), NUM_REQ));
               state_d = StIdle;
            end else if (req_valid[gnt_q]) begin
               state_d = StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         lock_q  <= 1'b0;
         last_q  <= 1'b0;
         gnt_q   <= '0;
         rr_q    <= '0;
         data_q  <= '0;
         baud_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         data_q  <= data_d;
         baud_q  <= baud_d;
         gap_q   <= gap_d;
      end
   end

   assign busy        = (state_q != StIdle) || lock_q;
   assign gnt_id      = gnt_q;
   assign tx_data     = data_q;
   assign tx_baud_set = baud_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_byte_tx model.
module tb_uart_tx_arbiter;

   localparam int unsigned NReq  = 4;
   localparam int unsigned Gap   = 100;
   localparam int          Frame = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NReq-1:0]   req_valid = '0;
   logic [8*NReq-1:0] req_data = '0;
   logic [NReq-1:0]   req_last = '0;
   logic [NReq-1:0]   req_ready;
   logic [2:0]        cfg_baud_set = 3'd0;
   logic [7:0]        tx_data;
   logic              tx_send_en;
   logic [2:0]        tx_baud_set;
   logic              tx_done;
   logic              tx_busy;
   logic              busy;
   logic [1:0]        gnt_id;
   logic              err_timeout;

   always #10 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ    (NReq),
      .GAP_CYCLES (Gap)
`ifdef UART_TX_TIMEOUT_EN
      ,
      .TIMEOUT    (50)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .cfg_baud_set (cfg_baud_set),
      .tx_data      (tx_data),
      .tx_send_en   (tx_send_en),
      .tx_baud_set  (tx_baud_set),
      .tx_done      (tx_done),
      .tx_busy      (tx_busy),
      .busy         (busy),
      .gnt_id       (gnt_id),
      .err_timeout  (err_timeout)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // uart_byte_tx stand-in: busy for Frame cycles after send_en, then a tx_done pulse.
   logic m_busy, m_done;
   int   m_cnt;
   bit   suppress_done = 1'b0;
   assign tx_busy = m_busy;
   assign tx_done = m_done;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (tx_send_en && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= Frame;
         end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= !suppress_done;
            end
         end
      end
   end

   logic [8:0] src_mem [NReq][16];
   int         head [NReq];
   int         tail [NReq];
   bit         pop_pend [NReq];
   logic [7:0] sent_data [64];
   logic [2:0] sent_baud [64];
   int         sent_cyc [64];
   int         done_cyc [64];
   int         n_sent = 0;
   int         n_done = 0;
   int         rdy_cnt [NReq];
   int         n_tests = 0;
   int         n_fail = 0;

   // Monitor, then requester sources: a byte is popped one cycle after its req_ready.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_send_en && n_sent < 64) begin
            sent_data[n_sent] = tx_data;
            sent_baud[n_sent] = tx_baud_set;
            sent_cyc[n_sent]  = cyc;
            n_sent++;
         end
         if (tx_done && n_done < 64) begin
            done_cyc[n_done] = cyc;
            n_done++;
         end
         for (int i = 0; i < NReq; i++) if (req_ready[i]) rdy_cnt[i]++;
      end
      for (int i = 0; i < NReq; i++) begin
         if (pop_pend[i] && head[i] != tail[i]) head[i]++;
         pop_pend[i] = req_ready[i];
         if (head[i] != tail[i]) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = src_mem[i][head[i] % 16][7:0];
            req_last[i]        = src_mem[i][head[i] % 16][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      src_mem[r][tail[r] % 16] = {l, d};
      tail[r]++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      suppress_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NReq; i++) begin
         head[i]     = 0;
         tail[i]     = 0;
         pop_pend[i] = 1'b0;
         rdy_cnt[i]  = 0;
      end
      n_sent = 0;
      n_done = 0;
      rst    = 1'b0;
   endtask

   task automatic wait_sends(input int k, input int budget, input string tag);
      for (int c = 0; c < budget && n_sent < k; c++) begin
         @(negedge clk);
         #1;
      end
      chk(tag, n_sent, k);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      for (int c = 0; c < budget && busy; c++) begin
         @(negedge clk);
         #1;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int push_cyc;
      logic [7:0] exp_lock [4];
      for (int i = 0; i < NReq; i++) begin
         head[i] = 0; tail[i] = 0; pop_pend[i] = 1'b0; rdy_cnt[i] = 0;
      end

      // Reset values while rst is held.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_send_en", {31'd0, tx_send_en}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_gnt", {30'd0, gnt_id}, 32'd0);
      chk("rst_baud", {29'd0, tx_baud_set}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_err", {31'd0, err_timeout}, 32'd0);

      // Single one-byte packet, baud 4.
      cfg_baud_set = 3'd4;
      do_reset();
      @(posedge clk);
      #1;
      push(0, 8'hAA, 1'b1);
      push_cyc = cyc;
      wait_sends(1, 100, "single_send");
      wait_idle(400, "single_idle");
      chk("single_data", {24'd0, sent_data[0]}, 32'hAA);
      chk("single_baud", {29'd0, sent_baud[0]}, 32'd4);
      chk("single_latency", sent_cyc[0] - push_cyc, 32'd2);
      chk("single_ready_cnt", rdy_cnt[0], 32'd1);
      chk("single_one_send", n_sent, 32'd1);
      chk("single_baud_out", {29'd0, tx_baud_set}, 32'd4);

      // Contention: all four valid together, twice.
      do_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      wait_sends(4, 1500, "cont_first4");
      for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
      wait_sends(8, 1500, "cont_second4");
      wait_idle(400, "cont_idle");
      for (int k = 0; k < 8; k++) chk($sformatf("cont_order%0d", k), {24'd0, sent_data[k]},
                                      32'h10 + (k % 4));

      // Packet lock: req1 three-byte packet beats req2 contiguously; gap spacing.
      do_reset();
      @(posedge clk);
      #1;
      push(1, 8'h55, 1'b0);
      push(1, 8'h56, 1'b0);
      push(1, 8'h57, 1'b1);
      push(2, 8'h99, 1'b1);
      exp_lock[0] = 8'h55; exp_lock[1] = 8'h56; exp_lock[2] = 8'h57; exp_lock[3] = 8'h99;
      wait_sends(4, 1500, "lock_sends");
      wait_idle(400, "lock_idle");
      for (int k = 0; k < 4; k++) chk($sformatf("lock_order%0d", k), {24'd0, sent_data[k]},
                                      {24'd0, exp_lock[k]});
      chk("gap_spacing0", sent_cyc[1] - done_cyc[0], Gap + 3);
      chk("gap_spacing1", sent_cyc[2] - done_cyc[1], Gap + 3);
      chk("lock_ready1", rdy_cnt[1], 32'd3);
      chk("lock_ready2", rdy_cnt[2], 32'd1);
      chk("lock_gnt", {30'd0, gnt_id}, 32'd2);

      // Baud code change mid-packet applies only to the next packet.
      cfg_baud_set = 3'd4;
      do_reset();
      @(posedge clk);
      #1;
      push(0, 8'hA0, 1'b0);
      push(0, 8'hA1, 1'b1);
      push(1, 8'hB0, 1'b1);
      wait_sends(1, 100, "baud_first");
      cfg_baud_set = 3'd1;
      wait_sends(3, 1000, "baud_all");
      wait_idle(400, "baud_idle");
      chk("baud_pkt0_b0", {29'd0, sent_baud[0]}, 32'd4);
      chk("baud_pkt0_b1", {29'd0, sent_baud[1]}, 32'd4);
      chk("baud_pkt1", {29'd0, sent_baud[2]}, 32'd1);
      chk("baud_pkt1_data", {24'd0, sent_data[2]}, 32'hB0);

      // Owner drops valid mid-packet: lock held, other requester starves until it resumes.
      do_reset();
      @(posedge clk);
      #1;
      push(0, 8'hC0, 1'b0);
      push(1, 8'hD0, 1'b1);
      wait_sends(1, 100, "hold_first");
      repeat (400) @(negedge clk);
      #1;
      chk("hold_no_send", n_sent, 32'd1);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_gnt", {30'd0, gnt_id}, 32'd0);
      @(posedge clk);
      #1;
      push(0, 8'hC1, 1'b1);
      wait_sends(3, 1000, "hold_resume");
      wait_idle(400, "hold_idle");
      chk("hold_c1", {24'd0, sent_data[1]}, 32'hC1);
      chk("hold_d0", {24'd0, sent_data[2]}, 32'hD0);

`ifdef UART_TX_TIMEOUT_EN
      begin
         int c;
         int err_cyc;
         do_reset();
         suppress_done = 1'b1;
         @(posedge clk);
         #1;
         push(0, 8'hE0, 1'b0);
         push(1, 8'hF0, 1'b1);
         wait_sends(1, 100, "to_first");
         c = 0;
         while (!err_timeout && c < 200) begin
            @(negedge clk);
            #1;
            c++;
         end
         err_cyc = cyc;
         chk("to_err", {31'd0, err_timeout}, 32'd1);
         chk("to_err_cycle", err_cyc - sent_cyc[0], 32'd51);
         wait_sends(2, 300, "to_next");
         chk("to_next_data", {24'd0, sent_data[1]}, 32'hF0);
         chk("to_sticky", {31'd0, err_timeout}, 32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
